// File: rtl/csr_regfile_if.sv
// ----------------------------------------------------------------------------
// csr_regfile_if
//   Bundles the CSR access and commit signals shared between the pipeline and
//   the CSR file.
//
//   Pipeline -> CSR file:
//     csr_rnum     read address (ID/EX)
//     csr_we       write strobe, already qualified by WB valid and ~wb_ex
//     csr_num      write address
//     csr_wmask    per-bit write mask
//     csr_wvalue   write data
//     wb_ex        exception commit
//     wb_ecode     exception code
//     wb_esubcode  exception subcode
//     wb_pc        PC of the excepting instruction
//     wb_badvaddr  faulting data address
//     ertn_flush   ertn commit
//
//   CSR file -> pipeline:
//     csr_rvalue   combinational read data
//     has_int      enabled interrupt pending
//     ex_entry     exception entry (EENTRY)
//     ertn_entry   ertn return address (ERA)
// ----------------------------------------------------------------------------
interface csr_regfile_if;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        ertn_flush;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;

  // Pipeline side: drives accesses and commits, consumes read data and entries.
  modport master (
    output csr_rnum, csr_we, csr_num, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_badvaddr, ertn_flush,
    input  csr_rvalue, has_int, ex_entry, ertn_entry
  );

  // CSR file side.
  modport slave (
    input  csr_rnum, csr_we, csr_num, csr_wmask, csr_wvalue,
           wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_badvaddr, ertn_flush,
    output csr_rvalue, has_int, ex_entry, ertn_entry
  );
endinterface

// File: rtl/csr_regfile.sv
// ----------------------------------------------------------------------------
// csr_regfile
//   LoongArch control/status register file. Responds to WB-stage CSR writes,
//   exception commits and ertn, serves combinational CSR reads, runs the
//   down-counting timer and raises the pending-interrupt flag.
//
//   Ports:
//     clk         clock
//     reset       synchronous reset, active-high, highest priority
//     hw_int_in   hardware interrupt lines, sampled into ESTAT.IS[9:2]
//     ipi_int_in  inter-processor interrupt, sampled into ESTAT.IS[12]
//     bus         csr_regfile_if.slave (read/write/commit bundle)
//
//   Parameters:
//     TID_RESET   reset value of TID
// ----------------------------------------------------------------------------
module csr_regfile #(
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    hw_int_in,
  input  logic          ipi_int_in,
  csr_regfile_if.slave  bus
);

  // CSR addresses
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // Software-writable bits per register; everything outside stays 0 forever,
  // which is what makes reserved bits read back as 0.
  localparam logic [31:0] WR_CRMD   = 32'h0000_01FF;
  localparam logic [31:0] WR_PRMD   = 32'h0000_0007;
  localparam logic [31:0] WR_ECFG   = 32'h0000_1BFF;
  localparam logic [31:0] WR_ESTAT  = 32'h0000_0003;
  localparam logic [31:0] WR_EENTRY = 32'hFFFF_FFC0;
  localparam logic [31:0] WR_FULL   = 32'hFFFF_FFFF;

  localparam logic [5:0]  ECODE_ADE  = 6'h08;
  localparam logic [5:0]  ECODE_ALE  = 6'h09;
  localparam logic [8:0]  ESUB_ADEF  = 9'h000;

  // Masked merge of a software write into an old value, restricted to the
  // register's writable bits.
  function automatic logic [31:0] mask_merge(
    input logic [31:0] old_val,
    input logic [31:0] wvalue,
    input logic [31:0] wmask,
    input logic [31:0] wr_bits
  );
    logic [31:0] eff_mask;
    eff_mask   = wmask & wr_bits;
    mask_merge = (old_val & ~eff_mask) | (wvalue & eff_mask);
  endfunction

  // Architectural state
  logic [31:0] crmd_r, prmd_r, ecfg_r, estat_r, era_r, badv_r, eentry_r;
  logic [31:0] save0_r, save1_r, save2_r, save3_r, tid_r, tcfg_r, tval_r;
  logic        armed_r;

  // Next-state values
  logic [31:0] crmd_nxt_s, prmd_nxt_s, ecfg_nxt_s, estat_nxt_s, era_nxt_s;
  logic [31:0] badv_nxt_s, eentry_nxt_s;
  logic [31:0] save0_nxt_s, save1_nxt_s, save2_nxt_s, save3_nxt_s;
  logic [31:0] tid_nxt_s, tcfg_nxt_s, tval_nxt_s;
  logic        armed_nxt_s;

  // Software-merged candidates and write decode
  logic [31:0] crmd_sw_s, prmd_sw_s;
  logic        crmd_we_s, prmd_we_s, ecfg_we_s, estat_we_s, era_we_s;
  logic        badv_we_s, eentry_we_s, save0_we_s, save1_we_s, save2_we_s;
  logic        save3_we_s, tid_we_s, tcfg_we_s, ticlr_we_s;
  logic        ticlr_clr_s, timer_fire_s;
  logic [31:0] rdata_s;

  assign crmd_we_s   = bus.csr_we && (bus.csr_num == CSR_CRMD);
  assign prmd_we_s   = bus.csr_we && (bus.csr_num == CSR_PRMD);
  assign ecfg_we_s   = bus.csr_we && (bus.csr_num == CSR_ECFG);
  assign estat_we_s  = bus.csr_we && (bus.csr_num == CSR_ESTAT);
  assign era_we_s    = bus.csr_we && (bus.csr_num == CSR_ERA);
  assign badv_we_s   = bus.csr_we && (bus.csr_num == CSR_BADV);
  assign eentry_we_s = bus.csr_we && (bus.csr_num == CSR_EENTRY);
  assign save0_we_s  = bus.csr_we && (bus.csr_num == CSR_SAVE0);
  assign save1_we_s  = bus.csr_we && (bus.csr_num == CSR_SAVE1);
  assign save2_we_s  = bus.csr_we && (bus.csr_num == CSR_SAVE2);
  assign save3_we_s  = bus.csr_we && (bus.csr_num == CSR_SAVE3);
  assign tid_we_s    = bus.csr_we && (bus.csr_num == CSR_TID);
  assign tcfg_we_s   = bus.csr_we && (bus.csr_num == CSR_TCFG);
  assign ticlr_we_s  = bus.csr_we && (bus.csr_num == CSR_TICLR);
  assign ticlr_clr_s = ticlr_we_s && bus.csr_wvalue[0] && bus.csr_wmask[0];

  assign crmd_sw_s = crmd_we_s ? mask_merge(crmd_r, bus.csr_wvalue, bus.csr_wmask, WR_CRMD) : crmd_r;
  assign prmd_sw_s = prmd_we_s ? mask_merge(prmd_r, bus.csr_wvalue, bus.csr_wmask, WR_PRMD) : prmd_r;

  // CRMD/PRMD: exception entry and ertn override the PLV/IE software write.
  always_comb begin
    crmd_nxt_s = crmd_sw_s;
    prmd_nxt_s = prmd_sw_s;
    if (bus.wb_ex) begin
      crmd_nxt_s[2:0] = 3'b000;
      prmd_nxt_s[2:0] = crmd_r[2:0];
    end else if (bus.ertn_flush) begin
      crmd_nxt_s[2:0] = prmd_r[2:0];
    end else begin
      crmd_nxt_s[2:0] = crmd_sw_s[2:0];
    end
  end

  // Simple software-only registers.
  always_comb begin
    ecfg_nxt_s   = ecfg_we_s   ? mask_merge(ecfg_r,   bus.csr_wvalue, bus.csr_wmask, WR_ECFG)   : ecfg_r;
    eentry_nxt_s = eentry_we_s ? mask_merge(eentry_r, bus.csr_wvalue, bus.csr_wmask, WR_EENTRY) : eentry_r;
    save0_nxt_s  = save0_we_s  ? mask_merge(save0_r,  bus.csr_wvalue, bus.csr_wmask, WR_FULL)   : save0_r;
    save1_nxt_s  = save1_we_s  ? mask_merge(save1_r,  bus.csr_wvalue, bus.csr_wmask, WR_FULL)   : save1_r;
    save2_nxt_s  = save2_we_s  ? mask_merge(save2_r,  bus.csr_wvalue, bus.csr_wmask, WR_FULL)   : save2_r;
    save3_nxt_s  = save3_we_s  ? mask_merge(save3_r,  bus.csr_wvalue, bus.csr_wmask, WR_FULL)   : save3_r;
    tid_nxt_s    = tid_we_s    ? mask_merge(tid_r,    bus.csr_wvalue, bus.csr_wmask, WR_FULL)   : tid_r;
  end

  // ERA and BADV: exception capture has priority over software writes.
  always_comb begin
    era_nxt_s  = era_r;
    badv_nxt_s = badv_r;
    if (bus.wb_ex) begin
      era_nxt_s = bus.wb_pc;
      if ((bus.wb_ecode == ECODE_ADE) && (bus.wb_esubcode == ESUB_ADEF)) begin
        badv_nxt_s = bus.wb_pc;
      end else if (bus.wb_ecode == ECODE_ALE) begin
        badv_nxt_s = bus.wb_badvaddr;
      end else begin
        badv_nxt_s = badv_r;
      end
    end else begin
      era_nxt_s  = era_we_s  ? mask_merge(era_r,  bus.csr_wvalue, bus.csr_wmask, WR_FULL) : era_r;
      badv_nxt_s = badv_we_s ? mask_merge(badv_r, bus.csr_wvalue, bus.csr_wmask, WR_FULL) : badv_r;
    end
  end

  // Timer: a TCFG write reloads and (re)arms without counting that cycle;
  // a one-shot disarms itself on expiry so it cannot fire again.
  always_comb begin
    tcfg_nxt_s   = tcfg_we_s ? mask_merge(tcfg_r, bus.csr_wvalue, bus.csr_wmask, WR_FULL) : tcfg_r;
    tval_nxt_s   = tval_r;
    armed_nxt_s  = armed_r;
    timer_fire_s = 1'b0;
    if (tcfg_we_s) begin
      tval_nxt_s  = {tcfg_nxt_s[31:2], 2'b00};
      armed_nxt_s = tcfg_nxt_s[0];
    end else if (tcfg_r[0] && armed_r) begin
      if (tval_r != 32'd0) begin
        tval_nxt_s = tval_r - 32'd1;
      end else begin
        timer_fire_s = 1'b1;
        if (tcfg_r[1]) begin
          tval_nxt_s = {tcfg_r[31:2], 2'b00};
        end else begin
          armed_nxt_s = 1'b0;
        end
      end
    end else begin
      tval_nxt_s = tval_r;
    end
  end

  // ESTAT: sampled interrupt lines, timer flag (set beats clear) and the
  // exception cause captured on commit.
  always_comb begin
    estat_nxt_s       = estat_r;
    estat_nxt_s[1:0]  = estat_we_s ? mask_merge(estat_r, bus.csr_wvalue, bus.csr_wmask, WR_ESTAT) >> 0 : estat_r[1:0];
    estat_nxt_s[9:2]  = hw_int_in;
    estat_nxt_s[10]   = 1'b0;
    estat_nxt_s[12]   = ipi_int_in;
    if (timer_fire_s) begin
      estat_nxt_s[11] = 1'b1;
    end else if (ticlr_clr_s) begin
      estat_nxt_s[11] = 1'b0;
    end else begin
      estat_nxt_s[11] = estat_r[11];
    end
    if (bus.wb_ex) begin
      estat_nxt_s[21:16] = bus.wb_ecode;
      estat_nxt_s[30:22] = bus.wb_esubcode;
    end else begin
      estat_nxt_s[30:16] = estat_r[30:16];
    end
  end

  // State register with synchronous reset taking priority over every update.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_r   <= 32'h0000_0008;
      prmd_r   <= 32'h0;
      ecfg_r   <= 32'h0;
      estat_r  <= 32'h0;
      era_r    <= 32'h0;
      badv_r   <= 32'h0;
      eentry_r <= 32'h0;
      save0_r  <= 32'h0;
      save1_r  <= 32'h0;
      save2_r  <= 32'h0;
      save3_r  <= 32'h0;
      tid_r    <= TID_RESET;
      tcfg_r   <= 32'h0;
      tval_r   <= 32'h0;
      armed_r  <= 1'b0;
    end else begin
      crmd_r   <= crmd_nxt_s;
      prmd_r   <= prmd_nxt_s;
      ecfg_r   <= ecfg_nxt_s;
      estat_r  <= estat_nxt_s;
      era_r    <= era_nxt_s;
      badv_r   <= badv_nxt_s;
      eentry_r <= eentry_nxt_s;
      save0_r  <= save0_nxt_s;
      save1_r  <= save1_nxt_s;
      save2_r  <= save2_nxt_s;
      save3_r  <= save3_nxt_s;
      tid_r    <= tid_nxt_s;
      tcfg_r   <= tcfg_nxt_s;
      tval_r   <= tval_nxt_s;
      armed_r  <= armed_nxt_s;
    end
  end

  // Combinational read mux; reads see the pre-write register contents.
  always_comb begin
    rdata_s = 32'h0;
    case (bus.csr_rnum)
      CSR_CRMD:   rdata_s = crmd_r;
      CSR_PRMD:   rdata_s = prmd_r;
      CSR_ECFG:   rdata_s = ecfg_r;
      CSR_ESTAT:  rdata_s = estat_r;
      CSR_ERA:    rdata_s = era_r;
      CSR_BADV:   rdata_s = badv_r;
      CSR_EENTRY: rdata_s = eentry_r;
      CSR_SAVE0:  rdata_s = save0_r;
      CSR_SAVE1:  rdata_s = save1_r;
      CSR_SAVE2:  rdata_s = save2_r;
      CSR_SAVE3:  rdata_s = save3_r;
      CSR_TID:    rdata_s = tid_r;
      CSR_TCFG:   rdata_s = tcfg_r;
      CSR_TVAL:   rdata_s = tval_r;
      CSR_TICLR:  rdata_s = 32'h0;
      default:    rdata_s = 32'h0;
    endcase
  end

  assign bus.csr_rvalue = rdata_s;
  assign bus.has_int    = crmd_r[2] & (|(estat_r[12:0] & ecfg_r[12:0]));
  assign bus.ex_entry   = eentry_r;
  assign bus.ertn_entry = era_r;

endmodule

// File: tb/tb_csr_regfile.sv
// ----------------------------------------------------------------------------
// tb_csr_regfile
//   Directed, self-checking bench for csr_regfile. Inputs change on the
//   falling edge; outputs are sampled in the low phase, away from the rising
//   edge that updates the registers.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_csr_regfile;

  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00C;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE1  = 14'h031;
  localparam logic [13:0] A_SAVE3  = 14'h033;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;
  localparam logic [13:0] A_UNMAP  = 14'h010;
  localparam logic [31:0] TID_INIT = 32'h1234_5678;

  logic       clk;
  logic       reset;
  logic [7:0] hw_int_in;
  logic       ipi_int_in;
  int         vectors;
  int         miscompares;

  csr_regfile_if bus ();

  csr_regfile #(.TID_RESET(TID_INIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .hw_int_in  (hw_int_in),
    .ipi_int_in (ipi_int_in),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [13:0] addr, input logic [31:0] exp);
    bus.csr_rnum = addr;
    #1;
    chk(tag, bus.csr_rvalue, exp);
  endtask

  task automatic wr(input logic [13:0] addr, input logic [31:0] mask, input logic [31:0] val);
    bus.csr_we     = 1'b1;
    bus.csr_num    = addr;
    bus.csr_wmask  = mask;
    bus.csr_wvalue = val;
    tick();
    bus.csr_we     = 1'b0;
  endtask

  task automatic exc(input logic [5:0] ecode, input logic [8:0] esub,
                     input logic [31:0] pc, input logic [31:0] badv);
    bus.wb_ex       = 1'b1;
    bus.wb_ecode    = ecode;
    bus.wb_esubcode = esub;
    bus.wb_pc       = pc;
    bus.wb_badvaddr = badv;
    tick();
    bus.wb_ex       = 1'b0;
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    hw_int_in        = 8'h00;
    ipi_int_in       = 1'b0;
    bus.csr_rnum     = 14'h0;
    bus.csr_we       = 1'b0;
    bus.csr_num      = 14'h0;
    bus.csr_wmask    = 32'h0;
    bus.csr_wvalue   = 32'h0;
    bus.wb_ex        = 1'b0;
    bus.wb_ecode     = 6'h0;
    bus.wb_esubcode  = 9'h0;
    bus.wb_pc        = 32'h0;
    bus.wb_badvaddr  = 32'h0;
    bus.ertn_flush   = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    rd("rst_crmd", A_CRMD, 32'h0000_0008);
    rd("rst_tid", A_TID, TID_INIT);
    rd("rst_estat", A_ESTAT, 32'h0);
    rd("rst_tval", A_TVAL, 32'h0);
    rd("rst_prmd", A_PRMD, 32'h0);
    chk("rst_has_int", {31'd0, bus.has_int}, 32'd0);
    chk("rst_ex_entry", bus.ex_entry, 32'h0);

    // Masked write, with a same-cycle read returning the old value
    bus.csr_we = 1'b1; bus.csr_num = A_SAVE0;
    bus.csr_wmask = 32'hFFFF_0000; bus.csr_wvalue = 32'hDEAD_BEEF;
    rd("save0_prewrite", A_SAVE0, 32'h0);
    tick();
    bus.csr_we = 1'b0;
    rd("save0_masked", A_SAVE0, 32'hDEAD_0000);
    wr(A_SAVE3, 32'hFFFF_FFFF, 32'hA5A5_5A5A);
    rd("save3_full", A_SAVE3, 32'hA5A5_5A5A);
    rd("save1_untouched", A_SAVE1, 32'h0);

    wr(A_EENTRY, 32'hFFFF_FFFF, 32'h1C00_00FF);
    rd("eentry_low_ro", A_EENTRY, 32'h1C00_00C0);
    chk("ex_entry", bus.ex_entry, 32'h1C00_00C0);

    wr(A_UNMAP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("unmapped_read", A_UNMAP, 32'h0);
    rd("ticlr_read", A_TICLR, 32'h0);
    wr(A_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("ecfg_bit10", A_ECFG, 32'h0000_1BFF);

    // Exception entry and ertn
    wr(A_CRMD, 32'h0000_0007, 32'h0000_0007);
    rd("crmd_plv3_ie", A_CRMD, 32'h0000_000F);
    chk("has_int_no_is", {31'd0, bus.has_int}, 32'd0);
    exc(6'h0B, 9'h0, 32'h1C00_0100, 32'h0);
    rd("ex_crmd", A_CRMD, 32'h0000_0008);
    rd("ex_prmd", A_PRMD, 32'h0000_0007);
    rd("ex_estat", A_ESTAT, 32'h000B_0000);
    rd("ex_era", A_ERA, 32'h1C00_0100);
    chk("ertn_entry", bus.ertn_entry, 32'h1C00_0100);
    rd("ex_badv_keep", A_BADV, 32'h0);
    bus.ertn_flush = 1'b1;
    tick();
    bus.ertn_flush = 1'b0;
    rd("ertn_crmd", A_CRMD, 32'h0000_000F);

    // BADV capture rules
    exc(6'h09, 9'h0, 32'h1C00_0300, 32'h0000_1003);
    rd("ale_badv", A_BADV, 32'h0000_1003);
    rd("ale_era", A_ERA, 32'h1C00_0300);
    exc(6'h08, 9'h0, 32'h1C00_0201, 32'h0000_FFFF);
    rd("adef_badv", A_BADV, 32'h1C00_0201);
    exc(6'h0C, 9'h1, 32'h1C00_0400, 32'h0000_5555);
    rd("other_badv", A_BADV, 32'h1C00_0201);
    rd("esub_estat", A_ESTAT, 32'h004C_0000);
    exc(6'h08, 9'h1, 32'h1C00_0500, 32'h0000_7777);
    rd("adem_badv", A_BADV, 32'h1C00_0201);

    // Interrupt sampling and has_int gating
    hw_int_in = 8'h01; ipi_int_in = 1'b1;
    tick();
    rd("is_hw_ipi", A_ESTAT, 32'h0048_1004);
    chk("has_int_ie0", {31'd0, bus.has_int}, 32'd0);
    wr(A_CRMD, 32'h0000_0004, 32'h0000_0004);
    rd("crmd_ie", A_CRMD, 32'h0000_000C);
    chk("has_int_hw", {31'd0, bus.has_int}, 32'd1);
    hw_int_in = 8'h00; ipi_int_in = 1'b0;
    tick();
    rd("is_cleared", A_ESTAT, 32'h0048_0000);
    chk("has_int_idle", {31'd0, bus.has_int}, 32'd0);
    wr(A_ESTAT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    rd("estat_sw", A_ESTAT, 32'h0048_0003);
    chk("has_int_swi", {31'd0, bus.has_int}, 32'd1);
    wr(A_ESTAT, 32'h0000_0003, 32'h0);
    rd("estat_sw_clr", A_ESTAT, 32'h0048_0000);
    wr(A_ECFG, 32'hFFFF_FFFF, 32'h0000_0800);
    rd("ecfg_timer", A_ECFG, 32'h0000_0800);

    // One-shot timer
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_000D);
    rd("tcfg", A_TCFG, 32'h0000_000D);
    rd("tval_load", A_TVAL, 32'd12);
    for (int k = 11; k >= 0; k--) begin
      tick();
      rd("tval_oneshot", A_TVAL, 32'(k));
    end
    rd("is11_before", A_ESTAT, 32'h0048_0000);
    tick();
    rd("is11_fire", A_ESTAT, 32'h0048_0800);
    chk("has_int_timer", {31'd0, bus.has_int}, 32'd1);
    rd("tval_hold", A_TVAL, 32'h0);
    repeat (3) tick();
    rd("tval_hold2", A_TVAL, 32'h0);
    wr(A_TICLR, 32'h0000_0001, 32'h0000_0001);
    rd("ticlr_clear", A_ESTAT, 32'h0048_0000);
    chk("has_int_clr", {31'd0, bus.has_int}, 32'd0);
    rd("tval_after_clr", A_TVAL, 32'h0);
    repeat (3) tick();
    rd("oneshot_norefire", A_ESTAT, 32'h0048_0000);

    // Periodic timer
    wr(A_TCFG, 32'hFFFF_FFFF, 32'h0000_0007);
    rd("ptval_load", A_TVAL, 32'd4);
    for (int k = 3; k >= 0; k--) begin
      tick();
      rd("tval_periodic", A_TVAL, 32'(k));
    end
    tick();
    rd("ptval_reload", A_TVAL, 32'd4);
    rd("p_is11", A_ESTAT, 32'h0048_0800);
    wr(A_TICLR, 32'h0000_0001, 32'h0000_0001);
    rd("p_clr", A_ESTAT, 32'h0048_0000);
    rd("p_tval_count", A_TVAL, 32'd3);
    repeat (3) tick();
    rd("p_tval_zero", A_TVAL, 32'd0);
    wr(A_TICLR, 32'h0000_0001, 32'h0000_0001);
    rd("set_beats_clr", A_ESTAT, 32'h0048_0800);
    rd("p_tval_reload2", A_TVAL, 32'd4);
    tick();
    rd("p_tval_midcount", A_TVAL, 32'd3);

    // Reset mid-count
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd("mid_rst_tval", A_TVAL, 32'h0);
    rd("mid_rst_tcfg", A_TCFG, 32'h0);
    rd("mid_rst_estat", A_ESTAT, 32'h0);
    rd("mid_rst_crmd", A_CRMD, 32'h0000_0008);
    rd("mid_rst_save0", A_SAVE0, 32'h0);
    repeat (3) tick();
    rd("mid_rst_nodec", A_TVAL, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
